// File: rtl/t10_lcd_arbiter.sv
// Round-robin arbiter sharing the 2x16 LCD between four frame requesters.
// Optional client-0 preemption of the dwell is enabled by defining T10_LCD_ARB_PREEMPT_EN.
module t10_lcd_arbiter #(
    parameter int unsigned DWELL_CYCLES = 800_000,
    parameter int unsigned CNT_W        = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [511:0] row_1_in,
    input  logic [511:0] row_2_in,
    output logic [3:0]   gnt,
    output logic [3:0]   ack,
    output logic [127:0] row_1,
    output logic [127:0] row_2,
    output logic         strobe,
    output logic         busy,
    output logic [1:0]   owner
);

    localparam int unsigned N_CLI  = 4;
    localparam int unsigned CLI_W  = 2;
    localparam int unsigned ROW_W  = 128;
    localparam int unsigned ROW_SH = $clog2(ROW_W);
    localparam int unsigned IDX_W  = CLI_W + ROW_SH;
    localparam logic [ROW_W-1:0] BLANK    = {16{8'h20}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DWELL = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CLI_W-1:0]   last_q, last_d;
    logic [CLI_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_CLI-1:0]   gnt_d, ack_d;
    logic [ROW_W-1:0]   row_1_d, row_2_d;
    logic               strobe_d, busy_d;
    logic [CLI_W-1:0]   owner_d;

    logic               rr_found;
    logic [CLI_W-1:0]   rr_idx;
    logic [CLI_W-1:0]   cand;
    logic [IDX_W-1:0]   base;

    function automatic logic [N_CLI-1:0] onehot(input logic [CLI_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Round-robin search starting just after the previous winner, wrapping to it last.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = last_q;
        cand     = last_q;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + CLI_W'(k);
            if (!rr_found && req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    assign base = {sel_q, ROW_SH'(0)};

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt;
        ack_d    = '0;
        strobe_d = 1'b0;
        row_1_d  = row_1;
        row_2_d  = row_2;
        owner_d  = owner;

        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    state_d = LOAD;
                    sel_d   = rr_idx;
                    gnt_d   = onehot(rr_idx);
                end
            end
            LOAD: begin
                row_1_d  = row_1_in[base +: ROW_W];
                row_2_d  = row_2_in[base +: ROW_W];
                owner_d  = sel_q;
                last_d   = sel_q;
                ack_d    = onehot(sel_q);
                strobe_d = 1'b1;
                cnt_d    = '0;
                state_d  = DWELL;
            end
            DWELL: begin
                cnt_d = cnt_q + CNT_W'(1);
`ifdef T10_LCD_ARB_PREEMPT_EN
                if (req[0] && (owner != CLI_W'(0))) begin
                    state_d = LOAD;
                    sel_d   = CLI_W'(0);
                    gnt_d   = onehot(CLI_W'(0));
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
`else
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= CLI_W'(3);
            sel_q   <= '0;
            cnt_q   <= '0;
            gnt     <= '0;
            ack     <= '0;
            strobe  <= 1'b0;
            busy    <= 1'b0;
            owner   <= '0;
            row_1   <= BLANK;
            row_2   <= BLANK;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            gnt     <= gnt_d;
            ack     <= ack_d;
            strobe  <= strobe_d;
            busy    <= busy_d;
            owner   <= owner_d;
            row_1   <= row_1_d;
            row_2   <= row_2_d;
        end
    end

endmodule
